fir_decim: RTL and testbench

Decimating real-valued FIR low-pass stage placed directly upstream of the de-emphasis IIR in the FM audio path. It consumes demodulated samples from a show-ahead FIFO and keeps a TAPS-deep sample history. After every DECIMATION input samples it computes one output with a sequential multiply-accumulate (one tap per cycle), then pushes the result into the output FIFO that feeds the IIR.

---
 rtl/fm_pkg.sv | 40 ++++
 rtl/fir_decim_if.sv | 33 +++
 rtl/fir_mac_tap.sv | 76 +++++++
 rtl/fir_decim.sv | 126 ++++++++++++
 tb/tb_fir_decim.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fm_pkg.sv
// rtl/fm_pkg.sv - shared FM audio path types, constants and dequantizer (used by FIR and IIR stages)
package fm_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    MAC   = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam int QUANT_BITS_DEFAULT = 10;

  // Widest product the dequantizer handles; covers DATA_SIZE up to 64.
  localparam int DEQ_MAX_W = 128;

  // Symmetric audio low-pass taps, Q10; index 0 multiplies the newest sample.
  localparam logic [0:31][31:0] AUDIO_LPF_COEFFS = {
    32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'hFFFF_FFFC,
    32'hFFFF_FFFE, 32'h0000_0002, 32'h0000_0008, 32'h0000_000F,
    32'h0000_0016, 32'h0000_001C, 32'h0000_0021, 32'h0000_0028,
    32'h0000_0032, 32'h0000_003C, 32'h0000_0046, 32'h0000_0050,
    32'h0000_0050, 32'h0000_0046, 32'h0000_003C, 32'h0000_0032,
    32'h0000_0028, 32'h0000_0021, 32'h0000_001C, 32'h0000_0016,
    32'h0000_000F, 32'h0000_0008, 32'h0000_0002, 32'hFFFF_FFFE,
    32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FFFD, 32'hFFFF_FFFE
  };

  // Fixed-point shift right that rounds toward zero instead of toward -inf.
  // Callers sign-extend a 2*DATA_SIZE product into p and cast the result
  // back down to DATA_SIZE.
  function automatic logic signed [DEQ_MAX_W-1:0] dequantize(
    input logic signed [DEQ_MAX_W-1:0] p,
    input int                          qbits
  );
    if (p < 0) begin
      return -((-p) >>> qbits);
    end
    return p >>> qbits;
  endfunction

endpackage

// File: rtl/fir_decim_if.sv
// rtl/fir_decim_if.sv - show-ahead input FIFO pop side and output FIFO push side of fir_decim
interface fir_decim_if #(
  parameter int DATA_SIZE = 32
) ();

  logic [DATA_SIZE-1:0] x_in;
  logic                 x_rd_en;
  logic                 x_empty;
  logic [DATA_SIZE-1:0] y_out;
  logic                 y_out_full;
  logic                 y_wr_en;

  // Filter side: pops samples, pushes results.
  modport master (
    input  x_in,
    input  x_empty,
    input  y_out_full,
    output x_rd_en,
    output y_out,
    output y_wr_en
  );

  // FIFO side: supplies samples, accepts results.
  modport slave (
    output x_in,
    output x_empty,
    output y_out_full,
    input  x_rd_en,
    input  y_out,
    input  y_wr_en
  );

endinterface

// File: rtl/fir_mac_tap.sv
// rtl/fir_mac_tap.sv - registered multiply, dequantize and accumulate datapath; FIR_SATURATE_EN clamps result
module fir_mac_tap
  import fm_pkg::*;
#(
  parameter int DATA_SIZE  = 32,
  parameter int QUANT_BITS = QUANT_BITS_DEFAULT,
  parameter int ACC_W      = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 en,
  input  logic [DATA_SIZE-1:0] coeff,
  input  logic [DATA_SIZE-1:0] sample,
  output logic                 busy,
  output logic [DATA_SIZE-1:0] result
);

  localparam int PROD_W = 2 * DATA_SIZE;

  logic signed [PROD_W-1:0]    prod;
  logic                        prod_v;
  logic signed [DATA_SIZE-1:0] deq;
  logic signed [ACC_W-1:0]     acc;

  // Product rounded toward zero, then truncated to sample width before summing
  always_comb begin
    deq = DATA_SIZE'(dequantize(DEQ_MAX_W'(prod), QUANT_BITS));
  end

  // Stage 1 registers the full-width product; stage 2 folds it into acc
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prod   <= '0;
      prod_v <= 1'b0;
      acc    <= '0;
    end else begin
      prod_v <= en;
      if (en) begin
        prod <= PROD_W'($signed(coeff)) * PROD_W'($signed(sample));
      end
      if (clear) begin
        acc <= '0;
      end else if (prod_v) begin
        acc <= acc + ACC_W'(deq);
      end
    end
  end

  // A product still in flight means acc is not final yet
  assign busy = prod_v;

`ifdef FIR_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_SIZE+1){1'b0}}, {(DATA_SIZE-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_SIZE+1){1'b1}}, {(DATA_SIZE-1){1'b0}}};

  // Clamp the wide accumulator into the signed sample range
  always_comb begin
    if (acc > SAT_MAX) begin
      result = SAT_MAX[DATA_SIZE-1:0];
    end else if (acc < SAT_MIN) begin
      result = SAT_MIN[DATA_SIZE-1:0];
    end else begin
      result = acc[DATA_SIZE-1:0];
    end
  end
`else
  // Accumulator already wraps at sample width
  always_comb begin
    result = acc;
  end
`endif

endmodule

// File: rtl/fir_decim.sv
// rtl/fir_decim.sv - decimating FIR low-pass with sequential MAC; FIR_SATURATE_EN selects wide acc + clamp
module fir_decim
  import fm_pkg::*;
#(
  parameter int TAPS       = 32,
  parameter int DECIMATION = 8,
  parameter int DATA_SIZE  = 32,
  parameter int QUANT_BITS = QUANT_BITS_DEFAULT,
  parameter logic [0:TAPS-1][DATA_SIZE-1:0] COEFFS = AUDIO_LPF_COEFFS
) (
  input logic         clock,
  input logic         reset,
  fir_decim_if.master bus
);

  localparam int DEC_W = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
  localparam int TAP_W = $clog2(TAPS);
  localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECIMATION - 1);
  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TAPS - 1);

`ifdef FIR_SATURATE_EN
  localparam int ACC_W = DATA_SIZE + $clog2(TAPS);
`else
  localparam int ACC_W = DATA_SIZE;
`endif

  state_t               state;
  logic [DATA_SIZE-1:0] hist [0:TAPS-1];
  logic [DEC_W-1:0]     dec_cnt;
  logic [TAP_W-1:0]     tap_idx;
  logic                 pop;
  logic                 last_pop;
  logic                 mac_en;
  logic                 mac_busy;
  logic [DATA_SIZE-1:0] mac_result;
  logic [DATA_SIZE-1:0] coeff_sel;
  logic [DATA_SIZE-1:0] sample_sel;
  logic [DATA_SIZE-1:0] y_out_q;
  logic                 y_wr_en_q;

  // Pop only while collecting samples; gated by reset so it drops immediately
  assign pop       = (state == LOAD) && !bus.x_empty && !reset;
  assign last_pop  = pop && (dec_cnt == DEC_LAST);
  assign mac_en    = (state == MAC);
  assign coeff_sel  = COEFFS[tap_idx];
  assign sample_sel = hist[tap_idx];

  assign bus.x_rd_en = pop;
  assign bus.y_out   = y_out_q;
  assign bus.y_wr_en = y_wr_en_q;

  // Sample history: newest at index 0, frozen outside LOAD
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) begin
        hist[k] <= '0;
      end
    end else if (pop) begin
      hist[0] <= bus.x_in;
      for (int k = 1; k < TAPS; k++) begin
        hist[k] <= hist[k-1];
      end
    end
  end

  // Control FSM: collect DECIMATION samples, run TAPS MAC cycles, push one result
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= LOAD;
      dec_cnt   <= '0;
      tap_idx   <= '0;
      y_out_q   <= '0;
      y_wr_en_q <= 1'b0;
    end else begin
      y_wr_en_q <= 1'b0;
      case (state)
        LOAD: begin
          if (pop) begin
            if (last_pop) begin
              dec_cnt <= '0;
              tap_idx <= '0;
              state   <= MAC;
            end else begin
              dec_cnt <= dec_cnt + 1'b1;
            end
          end
        end
        MAC: begin
          if (tap_idx == TAP_LAST) begin
            tap_idx <= '0;
            state   <= WRITE;
          end else begin
            tap_idx <= tap_idx + 1'b1;
          end
        end
        WRITE: begin
          // Wait for the last product to land in acc, then for room downstream
          if (!mac_busy && !bus.y_out_full) begin
            y_out_q   <= mac_result;
            y_wr_en_q <= 1'b1;
            state     <= LOAD;
          end
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

  fir_mac_tap #(
    .DATA_SIZE  (DATA_SIZE),
    .QUANT_BITS (QUANT_BITS),
    .ACC_W      (ACC_W)
  ) u_mac (
    .clock  (clock),
    .reset  (reset),
    .clear  (last_pop),
    .en     (mac_en),
    .coeff  (coeff_sel),
    .sample (sample_sel),
    .busy   (mac_busy),
    .result (mac_result)
  );

endmodule

// File: tb/tb_fir_decim.sv
// tb/tb_fir_decim.sv - randomized scoreboard bench for fir_decim against an arithmetic reference model
module tb_fir_decim;

  localparam int DS   = 32;
  localparam int TAPS = 8;
  localparam int DEC  = 3;
  localparam int QB   = 10;
  localparam logic [0:TAPS-1][DS-1:0] COEFFS = {
    32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0003, 32'hFFFF_FC00,
    32'h7FFF_FC00, 32'h0000_0005, 32'hFFFF_FFF9, 32'h0000_0040
  };

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  fir_decim_if #(.DATA_SIZE(DS)) bus ();

  fir_decim #(
    .TAPS       (TAPS),
    .DECIMATION (DEC),
    .DATA_SIZE  (DS),
    .QUANT_BITS (QB),
    .COEFFS     (COEFFS)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [DS-1:0] src_q [$];
  logic [DS-1:0] hist_m [$];
  logic [DS-1:0] exp_q [$];
  int            exp_edge [$];
  int  pops = 0;
  bit  busy = 1'b0;
  bit  stalled = 1'b0;
  bit  hold_full = 1'b0;
  bit  full_last = 1'b0;
  int  gap_pct = 0;
  int  full_pct = 0;
  logic [DS-1:0] last_y = '0;
  logic [DS-1:0] mon_exp;
  int  mon_edge;
  int  mon_lat;

  task automatic chk(input string name, input logic [DS-1:0] got, input logic [DS-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference: y = sum over taps of trunc_toward_zero(c[i]*x[n-i] / 2^QB), each term cut to 32 bits
  function automatic logic [DS-1:0] model_output();
    longint sum = 0;
    logic [0:TAPS-1][DS-1:0] c = COEFFS;
    for (int i = 0; i < TAPS; i++) begin
      longint xv;
      longint p;
      int     dq;
      xv = (i < hist_m.size()) ? longint'($signed(hist_m[i])) : 64'sd0;
      p  = longint'($signed(c[i])) * xv;
      dq = int'(p / (64'sd1 <<< QB));
      sum += longint'(dq);
    end
`ifdef FIR_SATURATE_EN
    if (sum > 64'sd2147483647) sum = 64'sd2147483647;
    else if (sum < -64'sd2147483648) sum = -64'sd2147483648;
`endif
    return DS'(sum);
  endfunction

  task automatic model_pop(input logic [DS-1:0] x);
    hist_m.push_front(x);
    if (hist_m.size() > TAPS) void'(hist_m.pop_back());
    pops++;
    if (pops == DEC) begin
      pops = 0;
      exp_q.push_back(model_output());
      exp_edge.push_back(cyc + 1);
      busy = 1'b1;
      stalled = 1'b0;
    end
  endtask

  function automatic logic [DS-1:0] rand_sample();
    case ($urandom_range(0, 5))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return DS'($urandom_range(0, 4095)) - 32'd2048;
      3: return 32'h0000_0001;
      default: return DS'($urandom);
    endcase
  endfunction

  always @(posedge clock) begin
    cyc++;
    full_last = bus.y_out_full;
  end

  // Monitor: every push must match the oldest pending expectation, on time, and not while full
  always @(negedge clock) begin
    if (!reset) begin
      if (busy && full_last) stalled = 1'b1;
      if (bus.y_wr_en === 1'b1) begin
        checks++;
        if (full_last) begin
          errors++;
          $display("FAIL wr_while_full: got y_wr_en 1 want 0 (cycle %0d)", cyc);
        end
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got y_out %h with no pending output (cycle %0d)", bus.y_out, cyc);
        end else begin
          mon_exp  = exp_q.pop_front();
          mon_edge = exp_edge.pop_front();
          chk("y_out", bus.y_out, mon_exp);
          mon_lat = cyc - mon_edge;
          checks++;
          if (stalled ? (mon_lat < TAPS + 2) : (mon_lat != TAPS + 2)) begin
            errors++;
            $display("FAIL latency: got %0d want %0d%s", mon_lat, TAPS + 2, stalled ? " or more" : "");
          end
        end
        busy = 1'b0;
        last_y = bus.y_out;
      end
    end
  end

  // One clock of input FIFO emulation; checks x_rd_en against the expected phase
  task automatic step();
    @(negedge clock);
    bus.x_empty    = (src_q.size() == 0) || (int'($urandom_range(0, 99)) < gap_pct);
    bus.x_in       = (src_q.size() != 0) ? src_q[0] : '0;
    bus.y_out_full = hold_full || (int'($urandom_range(0, 99)) < full_pct);
    #1;
    if (!reset) begin
      checks++;
      if (bus.x_rd_en !== (!busy && !bus.x_empty)) begin
        errors++;
        $display("FAIL x_rd_en: got %b want %b (cycle %0d)", bus.x_rd_en, !busy && !bus.x_empty, cyc);
      end
      if (bus.x_rd_en === 1'b1 && src_q.size() != 0) begin
        model_pop(src_q[0]);
        void'(src_q.pop_front());
      end
    end
  endtask

  task automatic run_until_idle(input int limit);
    int n = 0;
    while ((src_q.size() != 0 || busy) && n < limit) begin
      step();
      n++;
    end
    if (n >= limit) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending want 0 after %0d cycles", exp_q.size(), limit);
    end
  endtask

  task automatic wait_busy(input int limit);
    int n = 0;
    while (!busy && n < limit) begin
      step();
      n++;
    end
    chk("wait_busy", DS'(busy), DS'(1));
  endtask

  initial begin
    reset = 1'b1;
    bus.x_in = '0;
    bus.x_empty = 1'b1;
    bus.y_out_full = 1'b0;
    repeat (3) step();

    // Reset state, with data available so a leaking pop would show
    @(negedge clock);
    bus.x_empty = 1'b0;
    bus.x_in = 32'h1234_5678;
    #1;
    chk("reset_y_out", bus.y_out, '0);
    chk("reset_y_wr_en", DS'(bus.y_wr_en), '0);
    chk("reset_x_rd_en", DS'(bus.x_rd_en), '0);
    @(negedge clock);
    bus.x_empty = 1'b1;
    reset = 1'b0;

    // Impulse: outputs walk through the coefficients at the decimated phase
    src_q.push_back(32'd1024);
    repeat (23) src_q.push_back(32'd0);
    run_until_idle(2000);

    // Rounding toward zero on small and negative samples
    repeat (6) src_q.push_back(32'd1);
    repeat (6) src_q.push_back(32'hFFFF_F800);
    run_until_idle(2000);

    // Overflow-prone extremes
    repeat (9) src_q.push_back(32'h7FFF_FFFF);
    repeat (9) src_q.push_back(32'h8000_0000);
    run_until_idle(2000);

    // Random samples with input gaps and output backpressure
    gap_pct = 25;
    full_pct = 25;
    repeat (300) src_q.push_back(rand_sample());
    run_until_idle(20000);

    // Long stall in WRITE: no push, no pop, y_out held
    gap_pct = 0;
    full_pct = 0;
    repeat (12) src_q.push_back(rand_sample());
    wait_busy(50);
    hold_full = 1'b1;
    repeat (60) step();
    chk("stall_y_out", bus.y_out, last_y);
    chk("stall_pending", DS'(exp_q.size()), DS'(1));
    hold_full = 1'b0;
    run_until_idle(2000);

    // Reset part-way through the MAC: outputs clear at once, partial sum dropped
    repeat (12) src_q.push_back(rand_sample());
    wait_busy(50);
    repeat (5) step();
    #2;
    reset = 1'b1;
    bus.x_empty = 1'b0;
    #1;
    chk("midmac_y_wr_en", DS'(bus.y_wr_en), '0);
    chk("midmac_y_out", bus.y_out, '0);
    chk("midmac_x_rd_en", DS'(bus.x_rd_en), '0);
    src_q.delete();
    hist_m.delete();
    exp_q.delete();
    exp_edge.delete();
    pops = 0;
    busy = 1'b0;
    stalled = 1'b0;
    last_y = '0;
    repeat (2) step();
    @(negedge clock);
    bus.x_empty = 1'b1;
    reset = 1'b0;

    // Post-reset traffic uses only fresh samples
    gap_pct = 10;
    full_pct = 10;
    repeat (30) src_q.push_back(rand_sample());
    run_until_idle(5000);

    chk("final_pending", DS'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
